// File: rtl/apb_master.sv
// ============================================================================
// Module   : apb_master
// Purpose  : Single-outstanding APB master: turns one command into a
//            SETUP/ACCESS transfer and reports completion on rsp_*.
//            Optional ACCESS timeout when APB_MASTER_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= 8'h00;
            PWDATA    <= 8'h00;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? 8'h00 : PRDATA;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    // This cycle is the TIMEOUT_CYCLES-th consecutive wait: abort.
                    else if (wait_cnt == CNT_LAST) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 8'h00;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    cmd_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Scoreboard bench for apb_master with a wait-state APB slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic [7:0] PRDATA = 8'h00;
    logic       PREADY = 1'b1;

    apb_master #(.TIMEOUT_CYCLES(4)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         t0;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;
    int         pcnt = 0;
    int         wait_n = 0;
    int         acnt = 0;
    logic [7:0] rd_v = 8'h00;
    logic [7:0] cur_addr = 8'h00;
    logic [7:0] cur_wdata = 8'h00;
    logic       cur_write = 1'b0;
    logic       prev_psel = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge PCLK) pcnt <= pcnt + 1;

    // Response monitor, protocol checks and slave model, all on the falling edge.
    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("latency", pcnt - e.t0, e.lat);
                end
            end
            if (PSEL) check("ready_busy", cmd_ready, 0);
            if (PSEL && !PENABLE) check("idle_gap", prev_psel, 0);
            if (PSEL && PENABLE) begin
                check("paddr", PADDR, cur_addr);
                check("pwrite", PWRITE, cur_write);
                if (cur_write) check("pwdata", PWDATA, cur_wdata);
            end
        end
        prev_psel = PSEL;
        if (PSEL && PENABLE) begin
            if (acnt >= wait_n) begin
                PREADY = 1'b1;
                PRDATA = rd_v;
            end else begin
                PREADY = 1'b0;
                PRDATA = 8'($urandom);
            end
            acnt++;
        end else begin
            acnt   = 0;
            PREADY = 1'b1;
            PRDATA = 8'($urandom);
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic [7:0] rd, input logic err_exp,
                        input int lat_exp, input bit keep);
        int t0;
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        wait_n    = waits;
        rd_v      = rd;
        cur_addr  = a;
        cur_wdata = d;
        cur_write = w;
        t0        = pcnt;
        @(posedge PCLK);
        sbq.push_back('{rdata: (w || err_exp) ? 8'h00 : rd, err: err_exp, lat: lat_exp, t0: t0});
        @(negedge PCLK);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sbq.size() > 0 && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        if (sbq.size() > 0) begin
            check("rsp_timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(negedge PCLK);
    endtask

    initial begin
        logic       w;
        logic [7:0] a, d, rd;
        int         ws;

        repeat (2) @(negedge PCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 8'h00);
        check("rst_pwdata", PWDATA, 8'h00);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_cmd_ready", cmd_ready, 0);
        PRESETn = 1'b1;
        #1 check("ready_before_edge", cmd_ready, 0);
        @(negedge PCLK);
        check("ready_after_rst", cmd_ready, 1);

        // Zero-wait write, then read with three wait states.
        send(1'b1, 8'h05, 8'hA5, 0, 8'h00, 1'b0, 3, 1'b0);
        wait_done(50);
        send(1'b0, 8'h1F, 8'h00, 3, 8'h3C, 1'b0, 6, 1'b0);
        wait_done(50);

        // Back-to-back commands with cmd_valid held high.
        send(1'b1, 8'h10, 8'h11, 0, 8'h00, 1'b0, 3, 1'b1);
        send(1'b0, 8'h20, 8'h00, 1, 8'h77, 1'b0, 4, 0);
        wait_done(50);

        for (int i = 0; i < 6; i++) begin
            w  = 1'($urandom);
            a  = 8'($urandom);
            d  = 8'($urandom);
            rd = 8'($urandom);
            ws = int'($urandom_range(0, 3));
            send(w, a, d, ws, rd, 1'b0, 3 + ws, 1'b0);
            wait_done(50);
        end

        // Asynchronous reset during the ACCESS wait state.
        send(1'b0, 8'h33, 8'h00, 50, 8'h99, 1'b0, 53, 1'b0);
        repeat (3) @(negedge PCLK);
        check("wait_penable", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        check("arst_psel", PSEL, 0);
        check("arst_penable", PENABLE, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        sbq.delete();
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("ready_after_arst", cmd_ready, 1);
        check("no_rsp_after_arst", rsp_valid, 0);

        // Slave never ready (with timeout) or ready after 100 waits (without).
`ifdef APB_MASTER_TIMEOUT_EN
        send(1'b0, 8'h44, 8'h00, 200, 8'h55, 1'b1, 6, 1'b0);
        wait_done(50);
`else
        send(1'b0, 8'h44, 8'h00, 100, 8'h55, 1'b0, 103, 1'b0);
        repeat (100) @(negedge PCLK);
        check("hold_penable", PENABLE, 1);
        check("hold_rsp_err", rsp_err, 0);
        check("hold_pending", sbq.size(), 1);
        wait_done(50);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
